// File: rtl/pedestal_pkg.sv
// Shared types and constants for the pedestal subtraction path.
package pedestal_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned DIFF_W   = 17;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    TRACK   = 2'd1,
    HOLD    = 2'd2,
    RECOVER = 2'd3
  } state_t;

endpackage

// File: rtl/sat_sub16.sv
// Combinational 17-bit signed subtract (a - b) with saturation to 16 bits.
module sat_sub16
  import pedestal_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] i_a,
  input  logic signed [SAMPLE_W-1:0] i_b,
  output logic signed [DIFF_W-1:0]   o_diff,
  output logic signed [SAMPLE_W-1:0] o_sat
);

  always_comb begin
    o_diff = {i_a[SAMPLE_W-1], i_a} - {i_b[SAMPLE_W-1], i_b};
    // Top two bits disagree only when the result is outside the 16-bit range
    if (o_diff[DIFF_W-1] != o_diff[DIFF_W-2]) begin
      o_sat = o_diff[DIFF_W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      o_sat = o_diff[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/pedestal_subtractor.sv
// Pedestal subtraction with baseline freeze during pulses.
// Build option: PEDESTAL_INVERT_EN selects negative-going pulse polarity.
module pedestal_subtractor
  import pedestal_pkg::*;
#(
  parameter int          THRESH        = 100,
  parameter int unsigned HOLD_CYCLES   = 32,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned WARMUP_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic signed [SAMPLE_W-1:0] x,
  input  logic signed [SAMPLE_W-1:0] baseline,
  output logic signed [SAMPLE_W-1:0] y,
  output logic                       baseline_valid,
  output logic                       hold_active,
  output logic signed [SAMPLE_W-1:0] held_baseline
);

  localparam int unsigned MAX_HS = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_C  = (MAX_HS > WARMUP_CYCLES) ? MAX_HS : WARMUP_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MAX_C + 1);
  localparam logic signed [DIFF_W-1:0] THRESH_D = DIFF_W'(THRESH);

  state_t                       r_state, w_state_nxt;
  logic [CNT_W-1:0]             r_cnt, w_cnt_nxt;
  logic signed [SAMPLE_W-1:0]   r_x, r_held, r_y;
  logic                         r_valid, r_hold;
  logic signed [SAMPLE_W-1:0]   w_held_nxt, w_y_nxt;
  logic                         w_valid_nxt, w_hold_nxt;
  logic signed [DIFF_W-1:0]     w_diff;
  logic signed [SAMPLE_W-1:0]   w_sat;
  logic                         w_exc;

`ifdef PEDESTAL_INVERT_EN
  sat_sub16 u_sat_sub (.i_a(r_held), .i_b(r_x), .o_diff(w_diff), .o_sat(w_sat));
`else
  sat_sub16 u_sat_sub (.i_a(r_x), .i_b(r_held), .o_diff(w_diff), .o_sat(w_sat));
`endif

  assign w_exc = (w_diff > THRESH_D);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= WARMUP;
      r_cnt   <= '0;
      r_x     <= '0;
      r_held  <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_hold  <= 1'b0;
    end else if (enable) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x     <= x;
      r_held  <= w_held_nxt;
      r_y     <= w_y_nxt;
      r_valid <= w_valid_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Next state and shared warmup/hold/settle counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      WARMUP: begin
        if (r_cnt == CNT_W'(WARMUP_CYCLES - 1)) begin
          w_state_nxt = TRACK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      TRACK: begin
        if (w_exc) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (w_exc) begin
          w_cnt_nxt = CNT_W'(HOLD_CYCLES - 1);
        end else if (r_cnt == '0) begin
          w_state_nxt = RECOVER;
          w_cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RECOVER: begin
        if (w_exc) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
        end else if (r_cnt == '0) begin
          w_state_nxt = TRACK;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = WARMUP;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_held_nxt  = r_held;
    w_y_nxt     = w_sat;
    w_valid_nxt = r_valid;
    w_hold_nxt  = (w_state_nxt == HOLD) || (w_state_nxt == RECOVER);
    case (r_state)
      WARMUP: begin
        w_held_nxt = baseline;
        w_y_nxt    = '0;
        if (w_state_nxt == TRACK) w_valid_nxt = 1'b1;
      end
      TRACK: begin
        if (!w_exc) w_held_nxt = baseline;
      end
      default: ;
    endcase
  end

  assign y              = r_y;
  assign baseline_valid = r_valid;
  assign hold_active    = r_hold;
  assign held_baseline  = r_held;

endmodule

// File: tb/tb_pedestal_subtractor.sv
// Scoreboard bench for pedestal_subtractor: directed phases plus random traffic.
module tb_pedestal_subtractor;

  localparam int THRESH = 100;
  localparam int HOLD_N = 32;
  localparam int SETTLE_N = 8;
  localparam int WARM_N = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic signed [15:0] x = '0;
  logic signed [15:0] baseline = '0;
  logic signed [15:0] y;
  logic               baseline_valid;
  logic               hold_active;
  logic signed [15:0] held_baseline;

  pedestal_subtractor dut (
    .clk(clk), .reset(reset), .enable(enable), .x(x), .baseline(baseline),
    .y(y), .baseline_valid(baseline_valid), .hold_active(hold_active),
    .held_baseline(held_baseline)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y;
    bit valid;
    bit hold;
    int held;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: behaviour described per enabled sample in plain integers
  int m_xr = 0, m_held = 0, m_y = 0, m_wcnt = 0, m_quiet = 0;
  bit m_valid = 0, m_frozen = 0;

  function automatic int clamp16(input int d);
    if (d > 32767) return 32767;
    if (d < -32768) return -32768;
    return d;
  endfunction

  task automatic model_edge(input bit rst, input bit en, input int xv, input int bv);
    int d;
    bit e;
    exp_t t;
    if (rst) begin
      m_xr = 0; m_held = 0; m_y = 0; m_wcnt = 0; m_quiet = 0;
      m_valid = 0; m_frozen = 0;
    end else if (en) begin
`ifdef PEDESTAL_INVERT_EN
      d = m_held - m_xr;
`else
      d = m_xr - m_held;
`endif
      e = (d > THRESH);
      if (!m_valid) begin
        m_y = 0;
        m_held = bv;
        m_wcnt++;
        if (m_wcnt == WARM_N) m_valid = 1;
      end else begin
        m_y = clamp16(d);
        if (!m_frozen) begin
          if (e) begin
            m_frozen = 1;
            m_quiet = 0;
          end else begin
            m_held = bv;
          end
        end else if (e) begin
          m_quiet = 0;
        end else begin
          m_quiet++;
          if (m_quiet == HOLD_N + SETTLE_N) m_frozen = 0;
        end
      end
      m_xr = xv;
    end
    t.y = m_y; t.valid = m_valid; t.hold = m_frozen; t.held = m_held;
    exp_q.push_back(t);
  endtask

  task automatic step(input bit r, input bit e, input int xv, input int bv);
    @(negedge clk);
    reset = r;
    enable = e;
    x = 16'(xv);
    baseline = 16'(bv);
    @(posedge clk);
    model_edge(r, e, xv, bv);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: every clock edge presents a new output set to compare
  initial begin
    exp_t t;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
        t = exp_q.pop_front();
        check("y", int'(y), t.y);
        check("baseline_valid", int'(baseline_valid), int'(t.valid));
        check("hold_active", int'(hold_active), int'(t.hold));
        check("held_baseline", int'(held_baseline), t.held);
      end
    end
  end

  initial begin
    int b, xv, r;
    repeat (3) step(1, 0, 0, 0);
    // Warmup then tracking
    repeat (20) step(0, 1, 1000, 1000);
    repeat (4) step(0, 1, 1010, 1000);
    repeat (4) step(0, 1, 1010, 1005);
    // Pulse with drifting baseline, full hold and recovery
    for (int i = 0; i < 5; i++) step(0, 1, 1500, 1005 + i * 48);
    repeat (45) step(0, 1, 1005, 1200);
    // Retrigger during recovery, then an enable gap mid-hold
    repeat (2) step(0, 1, 1500, 1200);
    repeat (36) step(0, 1, 1200, 1200);
    step(0, 1, 1500, 1200);
    repeat (5) step(0, 1, 1200, 1200);
    for (int i = 0; i < 10; i++) step(0, 0, int'($urandom_range(0, 4000)), 1200);
    repeat (50) step(0, 1, 1200, 1200);
    // Saturation at both rails
    repeat (3) step(0, 1, -32768, -32768);
    repeat (3) step(0, 1, 32767, -32768);
    repeat (50) step(0, 1, -32768, 32767);
    // Reset in the middle of a hold
    repeat (4) step(0, 1, 1000, 1000);
    repeat (3) step(0, 1, 1500, 1000);
    step(1, 1, 1500, 1000);
    step(0, 0, 1500, 1000);
    repeat (20) step(0, 1, 500, 1000);
    repeat (10) step(0, 1, 1500, 1000);
    // Random traffic with pulses of both signs, gaps, extremes and resets
    b = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) b = int'($urandom_range(0, 8000)) - 4000;
      r = int'($urandom_range(0, 99));
      if (r < 6) xv = b + int'($urandom_range(150, 3000));
      else if (r < 12) xv = b - int'($urandom_range(150, 3000));
      else if (r < 14) xv = int'($urandom_range(0, 65535)) - 32768;
      else xv = b + int'($urandom_range(0, 60)) - 30;
      step($urandom_range(0, 399) == 0, $urandom_range(0, 9) < 8, xv, b);
    end
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
